// File: rtl/fp_accum_stream_if.sv
// Handshake bundle for the streaming floating-point accumulator.
// The master side produces terms and consumes results; the slave side is the accumulator.
interface fp_accum_stream_if #(
   parameter int EXP_LEN   = 6,
   parameter int MAN_LEN_1 = 11,
   parameter int MAN_LEN_2 = 15,
   parameter int CNT_LEN   = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic                 in_sign;
   logic [EXP_LEN-1:0]   in_exp;
   logic [MAN_LEN_1-1:0] in_man;
   logic                 in_last;
   logic                 clear;
   logic                 out_valid;
   logic                 out_ready;
   logic                 out_sign;
   logic [EXP_LEN-1:0]   out_exp;
   logic [MAN_LEN_2-1:0] out_man;
   logic [CNT_LEN-1:0]   out_count;
   logic                 out_ovf;

   modport master (
      output in_valid, in_sign, in_exp, in_man, in_last, clear, out_ready,
      input  in_ready, out_valid, out_sign, out_exp, out_man, out_count, out_ovf
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_man, in_last, clear, out_ready,
      output in_ready, out_valid, out_sign, out_exp, out_man, out_count, out_ovf
   );
endinterface

// File: rtl/fp_accum_stream.sv
// Accumulates a group of sign/exponent/mantissa terms, one per accepted beat,
// and holds the group sum for the consumer until it is taken.
//   state | meaning
//   IDLE  | no partial sum
//   ACC   | partial sum held
//   DONE  | result held, waiting for out_ready
module fp_accum_stream #(
   parameter int EXP_LEN   = 6,
   parameter int MAN_LEN_1 = 11,
   parameter int MAN_LEN_2 = 15,
   parameter int INT_LEN_1 = 1,
   parameter int INT_LEN_2 = 3,
   parameter int CNT_LEN   = 8
) (
   input  logic             clk,
   input  logic             reset,
   fp_accum_stream_if.slave bus
);

   localparam int PAD = INT_LEN_2 - INT_LEN_1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ACC  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]           state_q, state_d;
   logic                 acc_sign_q, acc_sign_d;
   logic [EXP_LEN-1:0]   acc_exp_q, acc_exp_d;
   logic [MAN_LEN_2-1:0] acc_man_q, acc_man_d;
   logic [CNT_LEN-1:0]   count_q, count_d;
   logic                 ovf_q, ovf_d;

   logic [MAN_LEN_1-1:0] in_man_w;
   logic [MAN_LEN_2-1:0] term_man;
   logic                 accept;
   logic                 term_big;
   logic [EXP_LEN-1:0]   exp_diff;
   logic [EXP_LEN-1:0]   big_exp;
   logic [MAN_LEN_2-1:0] big_man;
   logic [MAN_LEN_2-1:0] small_man;
   logic [MAN_LEN_2-1:0] small_al;
   logic                 big_sign;
   logic                 small_sign;
   logic [MAN_LEN_2:0]   sum;
   logic                 sum_sign;
   logic [MAN_LEN_2-1:0] add_man;
   logic [EXP_LEN-1:0]   add_exp;
   logic                 add_sign;
   logic                 add_ovf;
   logic [CNT_LEN-1:0]   count_inc;

   // Input mantissa widened so its integer bits line up with the accumulator's.
   assign in_man_w = bus.in_man;
   assign term_man = MAN_LEN_2'(in_man_w) << PAD;

   assign accept = bus.in_valid && (state_q != ST_DONE);

   always_comb begin
      term_big   = bus.in_exp > acc_exp_q;
      big_exp    = acc_exp_q;
      big_man    = acc_man_q;
      big_sign   = acc_sign_q;
      small_man  = term_man;
      small_sign = bus.in_sign;
      exp_diff   = acc_exp_q - bus.in_exp;
      if (term_big) begin
         big_exp    = bus.in_exp;
         big_man    = term_man;
         big_sign   = bus.in_sign;
         small_man  = acc_man_q;
         small_sign = acc_sign_q;
         exp_diff   = bus.in_exp - acc_exp_q;
      end
      small_al = small_man >> exp_diff;
   end

   // Magnitude add/subtract; an exact cancellation keeps the accumulator sign.
   always_comb begin
      sum      = '0;
      sum_sign = acc_sign_q;
      if (big_sign == small_sign) begin
         sum      = {1'b0, big_man} + {1'b0, small_al};
         sum_sign = big_sign;
      end else if (big_man > small_al) begin
         sum      = {1'b0, big_man - small_al};
         sum_sign = big_sign;
      end else if (small_al > big_man) begin
         sum      = {1'b0, small_al - big_man};
         sum_sign = small_sign;
      end
   end

   always_comb begin
      add_man  = sum[MAN_LEN_2-1:0];
      add_exp  = big_exp;
      add_sign = sum_sign;
      add_ovf  = 1'b0;
      if (sum[MAN_LEN_2]) begin
         if (&big_exp) begin
            add_man = '1;
            add_ovf = 1'b1;
         end else begin
            add_man = sum[MAN_LEN_2:1];
            add_exp = big_exp + 1'b1;
         end
      end
      if (add_man == '0) begin
         add_sign = 1'b0;
         add_exp  = '0;
      end
   end

   assign count_inc = (&count_q) ? count_q : count_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      acc_sign_d = acc_sign_q;
      acc_exp_d  = acc_exp_q;
      acc_man_d  = acc_man_q;
      count_d    = count_q;
      ovf_d      = ovf_q;
      if (bus.clear) begin
         state_d    = ST_IDLE;
         acc_sign_d = 1'b0;
         acc_exp_d  = '0;
         acc_man_d  = '0;
         count_d    = '0;
         ovf_d      = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  acc_sign_d = bus.in_sign;
                  acc_exp_d  = bus.in_exp;
                  acc_man_d  = term_man;
                  count_d    = CNT_LEN'(1);
                  ovf_d      = 1'b0;
                  state_d    = bus.in_last ? ST_DONE : ST_ACC;
               end
            end
            ST_ACC: begin
               if (accept) begin
                  acc_sign_d = add_sign;
                  acc_exp_d  = add_exp;
                  acc_man_d  = add_man;
                  count_d    = count_inc;
                  ovf_d      = ovf_q | add_ovf;
                  state_d    = bus.in_last ? ST_DONE : ST_ACC;
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         acc_sign_q <= 1'b0;
         acc_exp_q  <= '0;
         acc_man_q  <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_sign_q <= acc_sign_d;
         acc_exp_q  <= acc_exp_d;
         acc_man_q  <= acc_man_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
      end
   end

   assign bus.in_ready  = (state_q != ST_DONE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.out_sign  = acc_sign_q;
   assign bus.out_exp   = acc_exp_q;
   assign bus.out_man   = acc_man_q;
   assign bus.out_count = count_q;
   assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_fp_accum_stream.sv
// Bench for fp_accum_stream: directed literal cases plus randomized groups checked
// every cycle against an arithmetic reference of the accumulation rules.
module tb_fp_accum_stream;

   localparam int     EXP_LEN   = 6;
   localparam int     MAN_LEN_1 = 11;
   localparam int     MAN_LEN_2 = 15;
   localparam int     INT_LEN_1 = 1;
   localparam int     INT_LEN_2 = 3;
   localparam int     CNT_LEN   = 8;
   localparam int     PAD       = INT_LEN_2 - INT_LEN_1;
   localparam longint MAN_MAX   = (longint'(1) << MAN_LEN_2) - 1;
   localparam int     EXP_MAX   = (1 << EXP_LEN) - 1;
   localparam int     CNT_MAX   = (1 << CNT_LEN) - 1;

   logic clk;
   logic reset;

   fp_accum_stream_if #(
      .EXP_LEN(EXP_LEN), .MAN_LEN_1(MAN_LEN_1), .MAN_LEN_2(MAN_LEN_2), .CNT_LEN(CNT_LEN)
   ) bus ();

   fp_accum_stream #(
      .EXP_LEN(EXP_LEN), .MAN_LEN_1(MAN_LEN_1), .MAN_LEN_2(MAN_LEN_2),
      .INT_LEN_1(INT_LEN_1), .INT_LEN_2(INT_LEN_2), .CNT_LEN(CNT_LEN)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_tot  = 0;
   int n_pass = 0;

   function automatic void chk(input string name, input longint act, input longint exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endfunction

   // Reference: group value as (sign, exponent, mantissa integer); phase 0 empty,
   // 1 accumulating, 2 result waiting to be taken.
   int     m_phase = 0;
   int     m_sign  = 0;
   int     m_exp   = 0;
   longint m_man   = 0;
   int     m_cnt   = 0;
   int     m_ovf   = 0;

   function automatic void model_add(input int ts, input int te, input longint tm);
      int     be, bs, ss, rs;
      longint bm, sm, s;
      if (te > m_exp) begin
         be = te; bm = tm; bs = ts; sm = m_man >> (te - m_exp); ss = m_sign;
      end else begin
         be = m_exp; bm = m_man; bs = m_sign; sm = tm >> (m_exp - te); ss = ts;
      end
      if (bs == ss)     begin s = bm + sm; rs = bs; end
      else if (bm > sm) begin s = bm - sm; rs = bs; end
      else if (sm > bm) begin s = sm - bm; rs = ss; end
      else              begin s = 0;       rs = m_sign; end
      if (s > MAN_MAX) begin
         if (be == EXP_MAX) begin
            s = MAN_MAX;
            m_ovf = 1;
         end else begin
            s = s / 2;
            be = be + 1;
         end
      end
      m_man = s; m_exp = be; m_sign = rs;
      if (m_man == 0) begin m_sign = 0; m_exp = 0; end
   endfunction

   function automatic void model_step();
      longint tm;
      if (bus.clear) begin
         m_phase = 0; m_sign = 0; m_exp = 0; m_man = 0; m_cnt = 0; m_ovf = 0;
      end else if (m_phase == 2) begin
         if (bus.out_ready) m_phase = 0;
      end else if (bus.in_valid) begin
         tm = longint'(bus.in_man) << PAD;
         if (m_phase == 0) begin
            m_sign = int'(bus.in_sign); m_exp = int'(bus.in_exp); m_man = tm;
            m_cnt = 1; m_ovf = 0;
         end else begin
            model_add(int'(bus.in_sign), int'(bus.in_exp), tm);
            if (m_cnt < CNT_MAX) m_cnt++;
         end
         m_phase = bus.in_last ? 2 : 1;
      end
   endfunction

   always @(negedge clk) begin
      if (reset) begin
         chk("rst_out_valid", longint'(bus.out_valid), 0);
         chk("rst_out_count", longint'(bus.out_count), 0);
         chk("rst_out_ovf",   longint'(bus.out_ovf), 0);
         m_phase = 0; m_sign = 0; m_exp = 0; m_man = 0; m_cnt = 0; m_ovf = 0;
      end else begin
         chk("in_ready",  longint'(bus.in_ready),  longint'(m_phase != 2));
         chk("out_valid", longint'(bus.out_valid), longint'(m_phase == 2));
         if (m_phase == 2) begin
            chk("out_sign",  longint'(bus.out_sign),  m_sign);
            chk("out_exp",   longint'(bus.out_exp),   m_exp);
            chk("out_man",   longint'(bus.out_man),   m_man);
            chk("out_count", longint'(bus.out_count), m_cnt);
            chk("out_ovf",   longint'(bus.out_ovf),   m_ovf);
         end
         model_step();
      end
   end

   task automatic drive_term(input int s, input int e, input int m, input int l);
      bus.in_valid = 1'b1;
      bus.in_sign  = s[0];
      bus.in_exp   = EXP_LEN'(e);
      bus.in_man   = MAN_LEN_1'(m);
      bus.in_last  = l[0];
   endtask

   // Called just after a rising edge; returns just after the edge that took the term.
   task automatic send(input int s, input int e, input int m, input int l);
      bit got;
      got = 0;
      drive_term(s, e, m, l);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.in_ready && !bus.clear) begin
            got = 1;
            break;
         end
      end
      if (!got) begin
         n_tot++;
         $display("FAIL send_timeout: term not accepted within 50 cycles");
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic expect_res(input string name, input int s, input int e, input longint m,
                             input int c, input int o);
      bit got;
      got = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            got = 1;
            break;
         end
      end
      if (!got) begin
         n_tot++;
         $display("FAIL %s_timeout: no out_valid within 20 cycles", name);
      end else begin
         chk({name, "_sign"},  longint'(bus.out_sign),  s);
         chk({name, "_exp"},   longint'(bus.out_exp),   e);
         chk({name, "_man"},   longint'(bus.out_man),   m);
         chk({name, "_count"}, longint'(bus.out_count), c);
         chk({name, "_ovf"},   longint'(bus.out_ovf),   o);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   bit hold;

   initial begin
      reset         = 1'b1;
      bus.clear     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_sign   = 1'b0;
      bus.in_exp    = '0;
      bus.in_man    = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("post_reset_in_ready", longint'(bus.in_ready), 1);
      @(posedge clk); #1;

      send(0, 15, 'h400, 1);
      expect_res("single", 0, 15, 'h1000, 1, 0);

      send(0, 12, 'h400, 0);
      send(0, 10, 'h400, 1);
      expect_res("align", 0, 12, 'h1400, 2, 0);

      for (int i = 0; i < 8; i++) send(0, 15, 'h400, int'(i == 7));
      expect_res("renorm", 0, 16, 'h4000, 8, 0);

      send(0, 10, 'h400, 0);
      send(1, 10, 'h400, 1);
      expect_res("cancel", 0, 0, 0, 2, 0);

      // Result held under backpressure while a new term waits at the input.
      send(0, 15, 'h400, 1);
      drive_term(0, 12, 'h400, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready",  longint'(bus.in_ready),  0);
         chk("bp_out_valid", longint'(bus.out_valid), 1);
         chk("bp_out_man",   longint'(bus.out_man),   'h1000);
         chk("bp_out_exp",   longint'(bus.out_exp),   15);
         chk("bp_out_count", longint'(bus.out_count), 1);
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      chk("bp_idle_in_ready",  longint'(bus.in_ready),  1);
      chk("bp_idle_out_valid", longint'(bus.out_valid), 0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      expect_res("bp_pending", 0, 12, 'h1000, 1, 0);

      for (int i = 0; i < 8; i++) send(0, 63, 'h400, int'(i == 7));
      expect_res("sat", 0, 63, 'h7FFF, 8, 1);

      for (int i = 0; i < 260; i++) send(i % 2, 5, 'h400, int'(i == 259));
      expect_res("cnt_sat", 0, 0, 0, 255, 0);

      // Clear after two terms, with a competing term on the input.
      send(0, 10, 'h400, 0);
      send(0, 11, 'h400, 0);
      drive_term(0, 11, 'h400, 1);
      bus.clear = 1'b1;
      @(posedge clk); #1;
      bus.clear    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("clr_out_valid", longint'(bus.out_valid), 0);
         chk("clr_out_count", longint'(bus.out_count), 0);
         @(posedge clk); #1;
      end
      send(0, 9, 'h400, 1);
      expect_res("after_clear", 0, 9, 'h1000, 1, 0);

      send(0, 10, 'h400, 0);
      send(1, 12, 'h500, 0);
      reset = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rstmid_out_valid", longint'(bus.out_valid), 0);
         chk("rstmid_out_count", longint'(bus.out_count), 0);
         @(posedge clk); #1;
      end
      send(1, 20, 'h600, 1);
      expect_res("after_reset", 1, 20, 'h1800, 1, 0);

      hold = 1'b0;
      repeat (3000) begin
         if (!hold) begin
            if ($urandom_range(0, 3) != 0) begin
               if ($urandom_range(0, 7) == 0)
                  drive_term(int'($urandom_range(0, 1)), int'($urandom_range(55, 63)),
                             int'('h400 | $urandom_range(0, 'h3FF)),
                             int'($urandom_range(0, 3) == 0));
               else
                  drive_term(int'($urandom_range(0, 1)), int'($urandom_range(8, 20)),
                             int'('h400 | $urandom_range(0, 'h3FF)),
                             int'($urandom_range(0, 3) == 0));
            end else begin
               bus.in_valid = 1'b0;
            end
         end
         bus.clear     = ($urandom_range(0, 59) == 0);
         bus.out_ready = $urandom_range(0, 1) != 0;
         @(negedge clk);
         hold = bus.in_valid && !(bus.in_ready && !bus.clear);
         @(posedge clk); #1;
      end
      bus.in_valid  = 1'b0;
      bus.clear     = 1'b0;
      bus.out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/fp_accum_stream.md
FP_ACCUM_STREAM -- requirements
Module: fp_accum_stream

Interface
REQ-001 SHALL have parameter EXP_LEN, default 6, real (unbiased, unsigned) exponent width.
REQ-002 SHALL have parameter MAN_LEN_1, default 11, input mantissa width.
REQ-003 SHALL have parameter MAN_LEN_2, default 15, accumulator mantissa width; MAN_LEN_2 >= MAN_LEN_1 + (INT_LEN_2 - INT_LEN_1).
REQ-004 SHALL have parameter INT_LEN_1, default 1, input mantissa integer bits.
REQ-005 SHALL have parameter INT_LEN_2, default 3, accumulator integer bits; INT_LEN_2 >= INT_LEN_1.
REQ-006 SHALL have parameter CNT_LEN, default 8, term-counter width.
REQ-007 SHALL have ports: clk  in  1  sole clock, rising edge; reset  in  1  asynchronous, active-high.
REQ-008 SHALL have ports: in_valid in 1; in_ready out 1; in_sign in 1; in_exp in EXP_LEN; in_man in MAN_LEN_1; in_last in 1 (final term of group).
REQ-009 SHALL have port clear  in  1  synchronous discard of partial sum or held result.
REQ-010 SHALL have ports: out_valid out 1; out_ready in 1; out_sign out 1; out_exp out EXP_LEN; out_man out MAN_LEN_2 (INT_LEN_2 integer bits); out_count out CNT_LEN; out_ovf out 1.

Function
REQ-011 SHALL implement states IDLE (no partial sum), ACC (partial sum held), DONE (result held).
REQ-012 SHALL drive in_ready = 1 in IDLE/ACC, 0 in DONE; a term is accepted when in_valid & in_ready at a rising edge.
REQ-013 SHALL, on acceptance in IDLE, load accumulator with padded term: {zeros, in_man, (INT_LEN_2-INT_LEN_1) zeros}, exp and sign copied; count = 1.
REQ-014 SHALL, on acceptance in ACC, add term to accumulator: larger exponent kept, the other mantissa right-shifted by the difference (truncating), same signs add, differing signs subtract smaller magnitude from larger, result takes sign of larger (accumulator sign on tie).
REQ-015 SHALL compute the sum MAN_LEN_2+1 wide; if the top bit is set, store sum[MAN_LEN_2:1] and exp+1.
REQ-016 SHALL, if renormalisation is needed with exp at all-ones, store mantissa all-ones, keep exp, and set ovf sticky for the group.
REQ-017 SHALL, when the resulting mantissa is zero, store sign 0 and exp 0.
REQ-018 SHALL increment count per accepted term, saturating at all-ones.
REQ-019 SHALL transition IDLE->ACC (accept, !last), IDLE->DONE (accept, last), ACC->ACC (accept, !last), ACC->DONE (accept, last), DONE->IDLE (out_ready).
REQ-020 SHALL assert out_valid exactly in DONE; result visible the cycle after the last term is accepted (latency 1).
REQ-021 SHALL hold out_sign/out_exp/out_man/out_count/out_ovf stable while out_valid & !out_ready.
REQ-022 SHALL ignore in_valid while in DONE; the term is neither consumed nor lost (producer holds it).
REQ-023 SHALL give clear priority over acceptance: any state -> IDLE next cycle, accumulator, count, ovf zeroed, concurrent input not accepted.
REQ-024 SHALL drive out_* from registers only (no combinational path in->out).

Reset
REQ-025 SHALL, while reset high, force state IDLE, all accumulator registers, out_count, out_ovf, out_valid to 0; in_ready = 1 from the first edge after deassertion.
REQ-026 SHALL, on reset asserted mid-group or in DONE, discard the partial sum/result without emitting it.

Verification
REQ-027 Single term: sign 0, exp 15, man 11'h400, last -> next cycle out_valid, out_man 15'h1000, out_exp 15, out_count 1, out_ovf 0.
REQ-028 Alignment: (exp 12, man 11'h400) then (exp 10, man 11'h400, last) -> out_man 15'h1400, out_exp 12, out_count 2.
REQ-029 Renormalise: eight terms exp 15, man 11'h400, last on 8th -> out_man 15'h4000, out_exp 16, out_count 8.
REQ-030 Cancellation: (+, exp 10, 11'h400) then (-, exp 10, 11'h400, last) -> out_man 0, out_exp 0, out_sign 0.
REQ-031 Backpressure: result held with out_ready 0 for 3 cycles and in_valid 1 -> in_ready 0, outputs unchanged, no term accepted; out_ready 1 -> IDLE, pending term accepted next cycle.
REQ-032 Saturation/abort: terms at exp 63 summing past 8.0 -> out_man 15'h7FFF, out_exp 63, out_ovf 1; separately, clear or reset after 2 terms -> no out_valid, next group starts with count 1.
